// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB-to-memory completer.
//  - apb_state_t : completer FSM encoding (IDLE=0, SETUP=1, ACCESS=2)
//  - ADDR_W_DEF / DATA_W_DEF : default address and data widths
//  - mem_req_t   : memory-bus request bundle at the default widths
package apb_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2
    } apb_state_t;

    typedef struct packed {
        logic                  ce;
        logic                  wren;
        logic                  rden;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/apb_mem_slave.sv
// APB (v3-style) completer driving a simple synchronous memory bus.
// Ports:
//  clk, rst_n                      clock, asynchronous active-low reset
//  psel, penable, pwrite           APB control
//  paddr, pwdata, prdata, pready   APB address/data/handshake
//  id                              slot strap, 0 = unpopulated (all transfers ignored)
//  uses_sub_ready                  1 = pready follows mem_ready, 0 = zero-wait
//  mem_ce, mem_wren, mem_rden      memory strobes, active only in ACCESS
//  mem_addr, mem_wdata             memory address / write data
//  mem_rdata, mem_ready            memory read data / ready (wait request when low)
module apb_mem_slave
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    input  logic [1:0]        id,
    input  logic              uses_sub_ready,
    output logic              mem_ce,
    output logic              mem_wren,
    output logic              mem_rden,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    apb_state_t        state;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              wr_r;
    logic [DATA_W-1:0] prdata_r;
    logic              sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr_r   <= '0;
            wdata_r  <= '0;
            wr_r     <= 1'b0;
            prdata_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // sel && penable here is a held ACCESS phase, not a new transfer.
                    if (sel && !penable) begin
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    addr_r  <= paddr;
                    wdata_r <= pwdata;
                    wr_r    <= pwrite;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (!sel) begin
                        state <= IDLE;
                    end else if (pready) begin
                        if (!wr_r) begin
                            prdata_r <= mem_rdata;
                        end
                        state <= (sel && !penable) ? SETUP : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        sel       = psel && (id != 2'd0);
        pready    = (state == ACCESS) && (uses_sub_ready ? mem_ready : 1'b1);
        // Gating with sel makes an aborted transfer drop its strobes in the same cycle.
        mem_ce    = (state == ACCESS) && sel;
        mem_wren  = mem_ce && wr_r;
        mem_rden  = mem_ce && !wr_r;
        // The synchronous memory needs the address one cycle ahead of ACCESS so that
        // read data is already valid in the first ACCESS cycle.
        mem_addr  = (state == SETUP) ? paddr : addr_r;
        mem_wdata = wdata_r;
        prdata    = prdata_r;
    end

endmodule

// File: tb/tb_apb_mem_slave.sv
module tb_apb_mem_slave;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       psel, penable, pwrite;
    logic [7:0] paddr, pwdata, prdata;
    logic       pready;
    logic [1:0] id;
    logic       uses_sub_ready;
    logic       mem_ce, mem_wren, mem_rden;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_ready;

    always #5 clk = ~clk;

    apb_mem_slave #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .id(id),
        .uses_sub_ready(uses_sub_ready), .mem_ce(mem_ce), .mem_wren(mem_wren),
        .mem_rden(mem_rden), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    // Synchronous byte memory; ready goes high after cur_waits ACCESS cycles.
    logic [7:0] mem [256];
    logic       mem_clr;
    int         acc_cnt = 0;
    int         cur_waits = 0;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (mem_ce && mem_wren) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    always @(posedge clk) acc_cnt <= mem_ce ? acc_cnt + 1 : 0;
    assign mem_ready = (acc_cnt >= cur_waits);

    // Reference memory contents, as seen by the APB requester.
    logic [7:0] ref_mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One complete APB transfer; checks latency, strobes and (for reads) returned data.
    task automatic xfer(input logic wr, input logic [7:0] a, input logic [7:0] d,
                        input int w, input logic usr, input logic hold,
                        input logic [7:0] exp_rd);
        int   eff;
        int   n;
        int   acc;
        logic bad;
        logic done;
        eff  = usr ? w : 0;
        n    = 0;
        acc  = 0;
        bad  = 1'b0;
        done = 1'b0;
        cur_waits      = w;
        uses_sub_ready = usr;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        while (!done && n < 64) begin
            @(negedge clk);
            n++;
            if (mem_ce) begin
                acc++;
                if (mem_wren !== wr || mem_rden !== !wr || mem_addr !== a ||
                    (wr && mem_wdata !== d)) bad = 1'b1;
            end
            if (pready) done = 1'b1;
        end
        check("xfer_done", {31'd0, done}, 32'd1);
        check("xfer_cycles", n, 2 + eff);
        check("access_cycles", acc, 1 + eff);
        check("strobes_steady", {31'd0, bad}, 32'd0);
        @(posedge clk); #1;
        if (!hold) begin
            psel = 1'b0; penable = 1'b0;
        end
        @(negedge clk);
        check("idle_after", {31'd0, mem_ce}, 32'd0);
        if (!wr) check("prdata", {24'd0, prdata}, {24'd0, exp_rd});
        if (hold) begin
            @(posedge clk); #1;
            psel = 1'b0; penable = 1'b0;
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                check("no_retrigger", {31'd0, mem_ce | pready}, 32'd0);
            end
        end
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
        int         waits;
        logic       usr;
        logic       hold;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t       vecs[10];
    logic       r_wr, r_usr, r_hold;
    logic [7:0] r_a, r_d, r_exp;
    int         r_w;
    int         id0_bad;

    initial begin
        vecs[0] = '{1'b1, 8'h06, 8'h05, 0, 1'b1, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 8'h06, 8'h00, 0, 1'b1, 1'b0, 8'h05};
        vecs[2] = '{1'b1, 8'h05, 8'h04, 5, 1'b1, 1'b0, 8'h00};
        vecs[3] = '{1'b0, 8'h05, 8'h00, 5, 1'b1, 1'b0, 8'h04};
        vecs[4] = '{1'b1, 8'h04, 8'h03, 1, 1'b1, 1'b1, 8'h00};
        vecs[5] = '{1'b1, 8'h03, 8'h02, 3, 1'b1, 1'b0, 8'h00};
        vecs[6] = '{1'b0, 8'h04, 8'h00, 1, 1'b1, 1'b1, 8'h03};
        vecs[7] = '{1'b0, 8'h03, 8'h00, 3, 1'b1, 1'b0, 8'h02};
        vecs[8] = '{1'b1, 8'h10, 8'h77, 3, 1'b0, 1'b0, 8'h00};
        vecs[9] = '{1'b0, 8'h10, 8'h00, 3, 1'b0, 1'b0, 8'h77};
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'h00; pwdata = 8'h00; id = 2'd1; uses_sub_ready = 1'b1; mem_clr = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pready", {31'd0, pready}, 32'd0);
        check("rst_mem_ce", {31'd0, mem_ce | mem_wren | mem_rden}, 32'd0);
        check("rst_prdata", {24'd0, prdata}, 32'd0);
        check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; mem_clr = 1'b0;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].waits, vecs[i].usr,
                 vecs[i].hold, vecs[i].exp_rd);
            if (vecs[i].wr) ref_mem[vecs[i].addr] = vecs[i].data;
        end

        // Unpopulated slot: APB activity must never reach the memory
        id = 2'd0; id0_bad = 0; cur_waits = 0;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h06; pwdata = 8'hee;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (mem_ce || pready) id0_bad++;
        end
        check("id0_ignored", id0_bad, 0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; id = 2'd1;

        // psel dropped mid-ACCESS: strobes drop at once, no read data captured
        cur_waits = 3; uses_sub_ready = 1'b1;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h05;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_in_access", {31'd0, mem_rden}, 32'd1);
        #1;
        psel = 1'b0; cur_waits = 0;
        #1;
        check("abort_strobe_drop", {31'd0, mem_ce}, 32'd0);
        @(negedge clk);
        check("abort_idle", {31'd0, mem_ce | pready}, 32'd0);
        check("abort_prdata", {24'd0, prdata}, 32'h77);
        #1;
        penable = 1'b0;

        // Asynchronous reset in the middle of a waited read
        cur_waits = 5; uses_sub_ready = 1'b1;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h06;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_pre_access", {31'd0, mem_ce}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_strobes", {31'd0, mem_ce | mem_rden | mem_wren}, 32'd0);
        check("rst_mid_pready", {31'd0, pready}, 32'd0);
        check("rst_mid_prdata", {24'd0, prdata}, 32'd0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        xfer(1'b1, 8'h20, 8'h5a, 2, 1'b1, 1'b0, 8'h00);
        ref_mem[8'h20] = 8'h5a;
        xfer(1'b0, 8'h20, 8'h00, 0, 1'b1, 1'b0, 8'h5a);

        // Randomized transfers against the reference memory
        for (int i = 0; i < 40; i++) begin
            r_wr   = 1'($urandom_range(0, 1));
            r_a    = 8'($urandom_range(0, 255));
            r_d    = 8'($urandom_range(0, 255));
            r_w    = int'($urandom_range(0, 4));
            r_usr  = 1'($urandom_range(0, 1));
            r_hold = 1'($urandom_range(0, 1));
            r_exp  = ref_mem[r_a];
            xfer(r_wr, r_a, r_d, r_w, r_usr, r_hold, r_exp);
            if (r_wr) ref_mem[r_a] = r_d;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
